// File: rtl/pio_bus_master.sv
// pio_bus_master: Avalon-MM initiator for a single-register PIO slave.
// Serialises host read/write commands and runs an optional periodic
// autopoll of address 0, reporting which bits changed between polls.
module pio_bus_master #(
    parameter int unsigned POLL_PERIOD  = 1000,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [1:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    input  logic        poll_en,
    output logic [31:0] flags,
    output logic        flags_changed,
    output logic [31:0] changed_mask,
    output logic [1:0]  address,
    output logic        chipselect,
    output logic        write_n,
    output logic [31:0] writedata,
    input  logic [31:0] readdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        RD,
        RWAIT,
        DONE
    } state_t;

    localparam logic [23:0] POLL_LAST = 24'(POLL_PERIOD - 1);
    localparam logic [1:0]  LAT_LAST  = 2'(READ_LATENCY - 1);

    state_t      state;
    state_t      state_d;
    logic [23:0] poll_cnt;
    logic        poll_pending;
    logic        poll_wrap;
    logic        is_poll;
    logic [1:0]  lat_cnt;
    logic        accept;
    logic        start_poll;
    logic        sample;

    assign cmd_ready = (state == IDLE);
    assign poll_wrap = (poll_cnt == POLL_LAST);

    // Next-state logic: command beats pending poll; RWAIT spans the slave latency.
    always_comb begin
        state_d    = state;
        accept     = 1'b0;
        start_poll = 1'b0;
        sample     = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept  = 1'b1;
                    state_d = cmd_write ? WR : RD;
                end else if (poll_pending && poll_en) begin
                    start_poll = 1'b1;
                    state_d    = RD;
                end
            end
            WR:    state_d = IDLE;
            RD:    state_d = RWAIT;
            RWAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    sample  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Latency counter and poll/command tag for the read in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lat_cnt <= '0;
            is_poll <= 1'b0;
        end else begin
            lat_cnt <= (state == RWAIT) ? lat_cnt + 2'd1 : '0;
            if (accept) begin
                is_poll <= 1'b0;
            end else if (start_poll) begin
                is_poll <= 1'b1;
            end
        end
    end

    // Registered Avalon outputs, driven from the state being entered.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            address    <= '0;
            chipselect <= 1'b0;
            write_n    <= 1'b1;
            writedata  <= '0;
        end else begin
            if (accept) begin
                address <= cmd_addr;
            end else if (start_poll) begin
                address <= '0;
            end
            chipselect <= (state_d == WR) || (state_d == RD) || (state_d == RWAIT);
            write_n    <= (state_d != WR);
            writedata  <= (state_d == WR) ? cmd_wdata : '0;
        end
    end

    // Capture read data into the command response or the poll flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid     <= 1'b0;
            rsp_data      <= '0;
            flags         <= '0;
            flags_changed <= 1'b0;
            changed_mask  <= '0;
        end else begin
            rsp_valid     <= sample && !is_poll;
            flags_changed <= sample && is_poll && (readdata != flags);
            if (sample && !is_poll) begin
                rsp_data <= readdata;
            end
            if (sample && is_poll) begin
                flags        <= readdata;
                changed_mask <= readdata ^ flags;
            end
        end
    end

    // Poll timer; a wrap while a poll is already pending is dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else if (!poll_en) begin
            poll_cnt     <= '0;
            poll_pending <= 1'b0;
        end else begin
            poll_cnt <= poll_wrap ? '0 : poll_cnt + 24'd1;
            if (sample && is_poll) begin
                poll_pending <= 1'b0;
            end else if (poll_wrap) begin
                poll_pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pio_bus_master.sv
// Testbench for pio_bus_master: table-driven command vectors on a
// READ_LATENCY=1 instance, plus directed latency, reset, autopoll,
// poll-enable and arbitration sequences.
module tb_pio_bus_master;

    logic        clk;
    logic        reset_n;
    logic        cmd_valid1, cmd_valid3;
    logic        cmd_write;
    logic [1:0]  cmd_addr;
    logic [31:0] cmd_wdata;
    logic        poll_en1, poll_en3;
    logic [31:0] slave_in;

    logic        cmd_ready1, rsp_valid1, flags_changed1, chipselect1, write_n1;
    logic [31:0] rsp_data1, flags1, changed_mask1, writedata1, readdata1, slave_out1;
    logic [1:0]  address1;

    logic        cmd_ready3, rsp_valid3, flags_changed3, chipselect3, write_n3;
    logic [31:0] rsp_data3, flags3, changed_mask3, writedata3, readdata3;
    logic [31:0] pipe3_a, pipe3_b;
    logic [1:0]  address3;

    int checks = 0;
    int errors = 0;
    int poll_starts = 0;
    int rsp_cnt1 = 0;
    int both_high = 0;
    logic prev_cs1 = 1'b0;

    pio_bus_master #(.POLL_PERIOD(10), .READ_LATENCY(1)) u1 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid1), .cmd_ready(cmd_ready1), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid1), .rsp_data(rsp_data1), .poll_en(poll_en1),
        .flags(flags1), .flags_changed(flags_changed1), .changed_mask(changed_mask1),
        .address(address1), .chipselect(chipselect1), .write_n(write_n1),
        .writedata(writedata1), .readdata(readdata1)
    );

    pio_bus_master #(.POLL_PERIOD(10), .READ_LATENCY(3)) u3 (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid3), .rsp_data(rsp_data3), .poll_en(poll_en3),
        .flags(flags3), .flags_changed(flags_changed3), .changed_mask(changed_mask3),
        .address(address3), .chipselect(chipselect3), .write_n(write_n3),
        .writedata(writedata3), .readdata(readdata3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PIO slave model, latency 1: address 0 reads slave_in, writes go to slave_out1.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata1  <= '0;
            slave_out1 <= '0;
        end else begin
            readdata1 <= (address1 == 2'd0) ? slave_in : 32'd0;
            if (chipselect1 && !write_n1 && address1 == 2'd0) slave_out1 <= writedata1;
        end
    end

    // PIO slave model, latency 3.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pipe3_a   <= '0;
            pipe3_b   <= '0;
            readdata3 <= '0;
        end else begin
            pipe3_a   <= (address3 == 2'd0) ? slave_in : 32'd0;
            pipe3_b   <= pipe3_a;
            readdata3 <= pipe3_b;
        end
    end

    // Event counters for the latency-1 instance.
    always @(negedge clk) begin
        if (chipselect1 && write_n1 && address1 == 2'd0 && !prev_cs1) poll_starts++;
        prev_cs1 = chipselect1;
        if (rsp_valid1) rsp_cnt1++;
        if (rsp_valid1 && flags_changed1) both_high++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Wait for the next poll read on u1 and check its outcome.
    task automatic poll_check(input string name, input int exp_wait, input logic exp_pulse,
                              input logic [31:0] exp_mask, input logic [31:0] exp_flags);
        int k;
        int seen;
        int at;
        k = 0;
        seen = 0;
        at = -1;
        while (!chipselect1 && k < 40) begin
            tick();
            k++;
        end
        check({name, "_start"}, 32'(chipselect1), 32'd1);
        if (exp_wait != 0) check({name, "_wait"}, 32'(k), 32'(exp_wait));
        for (int i = 0; i < 4; i++) begin
            tick();
            if (flags_changed1) begin
                seen++;
                at = i;
            end
        end
        check({name, "_pulses"}, 32'(seen), 32'(exp_pulse));
        if (exp_pulse) begin
            check({name, "_pulse_at"}, 32'(at), 32'd1);
            check({name, "_mask"}, changed_mask1, exp_mask);
        end
        check({name, "_flags"}, flags1, exp_flags);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] sin;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[7];

    initial begin
        int k;
        int snap;
        int snap_r;

        vecs[0] = '{1'b1, 2'd0, 32'hA5A5_0001, 32'h0000_0000, 32'hA5A5_0001};
        vecs[1] = '{1'b0, 2'd0, 32'h0000_0000, 32'h1234_5678, 32'h1234_5678};
        vecs[2] = '{1'b0, 2'd1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vecs[3] = '{1'b1, 2'd1, 32'hDEAD_BEEF, 32'h1234_5678, 32'hA5A5_0001};
        vecs[4] = '{1'b1, 2'd0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000};
        vecs[5] = '{1'b0, 2'd3, 32'h0000_0000, 32'hCAFE_F00D, 32'h0000_0000};
        vecs[6] = '{1'b0, 2'd0, 32'h0000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};

        reset_n    = 1'b0;
        cmd_valid1 = 1'b0;
        cmd_valid3 = 1'b0;
        cmd_write  = 1'b0;
        cmd_addr   = 2'd0;
        cmd_wdata  = '0;
        poll_en1   = 1'b0;
        poll_en3   = 1'b0;
        slave_in   = '0;

        // Reset state.
        repeat (3) tick();
        check("rst_cmd_ready", 32'(cmd_ready1), 32'd1);
        check("rst_cs", 32'(chipselect1), 32'd0);
        check("rst_write_n", 32'(write_n1), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid1), 32'd0);
        check("rst_flags", flags1, 32'd0);
        check("rst_writedata", writedata1, 32'd0);
        check("rst_cs3", 32'(chipselect3), 32'd0);
        reset_n = 1'b1;
        repeat (2) tick();

        // Command vectors on the latency-1 instance.
        for (int i = 0; i < 7; i++) begin
            slave_in   = vecs[i].sin;
            cmd_write  = vecs[i].wr;
            cmd_addr   = vecs[i].addr;
            cmd_wdata  = vecs[i].wdata;
            cmd_valid1 = 1'b1;
            check($sformatf("vec%0d_ready", i), 32'(cmd_ready1), 32'd1);
            tick();
            cmd_valid1 = 1'b0;
            check($sformatf("vec%0d_cs", i), 32'(chipselect1), 32'd1);
            check($sformatf("vec%0d_addr", i), 32'(address1), 32'(vecs[i].addr));
            if (vecs[i].wr) begin
                check($sformatf("vec%0d_write_n", i), 32'(write_n1), 32'd0);
                check($sformatf("vec%0d_wdata", i), writedata1, vecs[i].wdata);
                tick();
                check($sformatf("vec%0d_cs_off", i), 32'(chipselect1), 32'd0);
                check($sformatf("vec%0d_wdata_off", i), writedata1, 32'd0);
                check($sformatf("vec%0d_ready_again", i), 32'(cmd_ready1), 32'd1);
                check($sformatf("vec%0d_slave_out", i), slave_out1, vecs[i].exp);
            end else begin
                check($sformatf("vec%0d_write_n", i), 32'(write_n1), 32'd1);
                k = 1;
                while (!rsp_valid1 && k < 10) begin
                    tick();
                    k++;
                end
                check($sformatf("vec%0d_latency", i), 32'(k), 32'd3);
                check($sformatf("vec%0d_rsp_data", i), rsp_data1, vecs[i].exp);
                tick();
                check($sformatf("vec%0d_rsp_pulse", i), 32'(rsp_valid1), 32'd0);
                check($sformatf("vec%0d_ready_again", i), 32'(cmd_ready1), 32'd1);
            end
        end

        // Read latency 3 instance: address 0 then address 1.
        for (int a = 0; a < 2; a++) begin
            slave_in   = 32'h1234_5678;
            cmd_write  = 1'b0;
            cmd_addr   = 2'(a);
            cmd_valid3 = 1'b1;
            tick();
            cmd_valid3 = 1'b0;
            k = 1;
            while (!rsp_valid3 && k < 12) begin
                tick();
                k++;
            end
            check($sformatf("lat3_a%0d_latency", a), 32'(k), 32'd5);
            check($sformatf("lat3_a%0d_data", a), rsp_data3, (a == 0) ? 32'h1234_5678 : 32'd0);
            tick();
            check($sformatf("lat3_a%0d_ready", a), 32'(cmd_ready3), 32'd1);
        end

        // Reset in the middle of a read.
        slave_in   = 32'h1234_5678;
        cmd_addr   = 2'd0;
        cmd_valid1 = 1'b1;
        tick();
        cmd_valid1 = 1'b0;
        tick();
        check("midrst_busy", 32'(chipselect1), 32'd1);
        reset_n = 1'b0;
        tick();
        check("midrst_cs", 32'(chipselect1), 32'd0);
        check("midrst_write_n", 32'(write_n1), 32'd1);
        check("midrst_address", 32'(address1), 32'd0);
        check("midrst_writedata", writedata1, 32'd0);
        check("midrst_rsp_data", rsp_data1, 32'd0);
        check("midrst_flags", flags1, 32'd0);
        check("midrst_mask", changed_mask1, 32'd0);
        reset_n = 1'b1;
        snap_r = rsp_cnt1;
        repeat (6) tick();
        check("midrst_no_rsp", 32'(rsp_cnt1 - snap_r), 32'd0);
        check("midrst_ready", 32'(cmd_ready1), 32'd1);

        // Autopoll: 0 -> 5 -> 4 -> 4.
        slave_in = 32'h0;
        poll_en1 = 1'b1;
        poll_check("poll_same0", 11, 1'b0, 32'h0, 32'h0);
        slave_in = 32'h5;
        poll_check("poll_to5", 0, 1'b1, 32'h5, 32'h5);
        slave_in = 32'h4;
        poll_check("poll_to4", 0, 1'b1, 32'h1, 32'h4);
        poll_check("poll_same4", 0, 1'b0, 32'h0, 32'h4);

        // Drop poll_en while a poll is in RWAIT.
        slave_in = 32'h80;
        k = 0;
        while (!chipselect1 && k < 40) begin
            tick();
            k++;
        end
        check("pen_start", 32'(chipselect1), 32'd1);
        tick();
        poll_en1 = 1'b0;
        tick();
        check("pen_pulse", 32'(flags_changed1), 32'd1);
        check("pen_flags", flags1, 32'h80);
        check("pen_mask", changed_mask1, 32'h84);
        tick();
        check("pen_counter", 32'(u1.poll_cnt), 32'd0);
        snap = poll_starts;
        repeat (30) tick();
        check("pen_no_polls", 32'(poll_starts - snap), 32'd0);

        // Arbitration: commands held through two wraps, then one poll.
        snap   = poll_starts;
        snap_r = rsp_cnt1;
        cmd_write  = 1'b0;
        cmd_addr   = 2'd1;
        cmd_valid1 = 1'b1;
        poll_en1   = 1'b1;
        repeat (24) tick();
        check("arb_no_poll_during_cmds", 32'(poll_starts - snap), 32'd0);
        check("arb_cmds_served", 32'(rsp_cnt1 - snap_r), 32'd6);
        check("arb_idle", 32'(cmd_ready1), 32'd1);
        cmd_valid1 = 1'b0;
        tick();
        check("arb_poll_cs", 32'(chipselect1), 32'd1);
        check("arb_poll_addr", 32'(address1), 32'd0);
        check("arb_poll_write_n", 32'(write_n1), 32'd1);
        repeat (4) tick();
        check("arb_one_poll", 32'(poll_starts - snap), 32'd1);
        check("arb_flags", flags1, 32'h80);
        check("never_both_high", 32'(both_high), 32'd0);

        poll_en1 = 1'b0;
        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
